// File: rtl/serial_comp_pkg.sv
// Shared constants for the serial magnitude comparator.
//   CHUNK  : operand bits consumed per cycle (width of the comparator slice)
//   S_*    : FSM state encodings (2'b11 is unused and recovers to S_IDLE)
package serial_comp_pkg;

  localparam int unsigned CHUNK = 2;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/two_bit_comp.sv
// Two-bit magnitude comparator slice with chain inputs.
// Ports:
//   a_i, b_i   : 2-bit chunks of operands A and B
//   eq_prev_i  : more-significant chunks were all equal
//   gt_prev_i  : more-significant chunks already decided A > B
//   eq_o, gt_o : chained result including this chunk
// Once an earlier chunk has decided the comparison, the result passes through unchanged.
module two_bit_comp (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       eq_prev_i,
  input  logic       gt_prev_i,
  output logic       eq_o,
  output logic       gt_o
);

  logic undecided;

  assign undecided = eq_prev_i & ~gt_prev_i;
  assign eq_o      = undecided & (a_i == b_i);
  assign gt_o      = (undecided & (a_i > b_i)) | (~eq_prev_i & gt_prev_i);

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle magnitude comparator. Operands are shifted out MSB-first, CHUNK bits per cycle,
// through a single two_bit_comp slice whose EQ/GT outputs are registered and fed back as its
// chain inputs. Result appears a fixed WIDTH/CHUNK cycles after accept.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-low reset
//   in_valid, in_ready   : operand handshake (a, b latched on accept)
//   out_valid, out_ready : result handshake
//   eq, gt, lt           : one-hot result while out_valid, otherwise 0
// Build option: define SERIAL_MAG_COMP_SIGNED_EN for two's-complement compare (the operand
// sign bits are inverted in the first RUN cycle, i.e. offset-binary mapping).
module serial_mag_comp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam logic [CNTW-1:0] CntInit = CNTW'(WIDTH / CHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;

  logic [1:0] chunk_a, chunk_b;
  logic       slice_eq, slice_gt;

  always_comb begin
    chunk_a = sa_q[WIDTH-1 -: CHUNK];
    chunk_b = sb_q[WIDTH-1 -: CHUNK];
`ifdef SERIAL_MAG_COMP_SIGNED_EN
    // Flipping the sign bits maps two's complement onto offset binary for the unsigned slice.
    if (cnt_q == CntInit) begin
      chunk_a[1] = ~chunk_a[1];
      chunk_b[1] = ~chunk_b[1];
    end
`endif
  end

  two_bit_comp u_slice (
    .a_i       (chunk_a),
    .b_i       (chunk_b),
    .eq_prev_i (eq_q),
    .gt_prev_i (gt_q),
    .eq_o      (slice_eq),
    .gt_o      (slice_gt)
  );

  always_comb begin
    state_d = state_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          cnt_d   = CntInit;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        eq_d  = slice_eq;
        gt_d  = slice_gt;
        sa_d  = sa_q << CHUNK;
        sb_d  = sb_q << CHUNK;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign eq        = out_valid & eq_q;
  assign gt        = out_valid & gt_q;
  assign lt        = out_valid & ~eq_q & ~gt_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp: the driver pushes the model's expected result at each
// accept; an independent monitor checks every cycle the DUT presents a result.
module tb_serial_mag_comp;

  localparam int W   = 32;
  localparam int LAT = W / 2;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   accept;
    bit   seen;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         eq, gt, lt;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  serial_mag_comp #(.WIDTH(W), .CNTW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer comparison of the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    bit   less, more;
`ifdef SERIAL_MAG_COMP_SIGNED_EN
    less = $signed(x) < $signed(y);
    more = $signed(x) > $signed(y);
`else
    less = x < y;
    more = x > y;
`endif
    e.eq = !less && !more;
    e.gt = more;
    e.lt = less;
    e.accept = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  // Monitor: every cycle a result is presented it must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        if (!sb_q[0].seen) begin
          chk("latency", cyc - sb_q[0].accept, LAT);
          sb_q[0].seen = 1'b1;
        end
        chk("eq", int'(eq), int'(sb_q[0].eq));
        chk("gt", int'(gt), int'(sb_q[0].gt));
        chk("lt", int'(lt), int'(sb_q[0].lt));
        chk("in_ready_low_in_done", int'(in_ready), 0);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall);
    int   n;
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1;
    a = x;
    b = y;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(x, y);
    e.accept = cyc + 1;
    sb_q.push_back(e);
    @(negedge clock);
    // During stall keep offering different operands; they must not be taken.
    in_valid = (stall > 0);
    a = $urandom;
    b = $urandom;
    n = 0;
    while (!out_valid && n < LAT + 10) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) begin
      chk("result_timeout", 0, 1);
      in_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    repeat (stall) @(negedge clock);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("in_ready_after_handoff", int'(in_ready), 1);
    chk("out_valid_after_handoff", int'(out_valid), 0);
  endtask

  initial begin
    logic [W-1:0] x, y;
    // Reset held with operands offered: nothing accepted.
    in_valid = 1'b1;
    a = 32'h1;
    b = 32'h2;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_eq_gt_lt", int'({eq, gt, lt}), 0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("idle_after_rst", int'(in_ready), 1);

    run_op(32'h12345678, 32'h12345678, 0);
    run_op(32'h00000005, 32'h00000006, 0);
    run_op(32'h00000006, 32'h00000005, 0);
    run_op(32'hC0000000, 32'h40000000, 0);
    run_op(32'h80000000, 32'h7FFFFFFF, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 0);
    run_op(32'hDEADBEEF, 32'h00C0FFEE, 10);

    // Abort in the middle of RUN.
    @(negedge clock);
    in_valid = 1'b1;
    a = 32'h11111111;
    b = 32'h22222222;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_in_ready", int'(in_ready), 1);
    repeat (LAT + 4) begin
      @(negedge clock);
      chk("abort_no_out_valid", int'(out_valid), 0);
    end
    run_op(32'd3, 32'd3, 0);

    // Randomised operands, some sharing a prefix so the decision lands in a late chunk.
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      case (i % 4)
        0: y = $urandom;
        1: y = x;
        2: y = x ^ (32'h1 << $urandom_range(0, W - 1));
        default: y = {x[W-1:8], 8'($urandom)};
      endcase
      run_op(x, y, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
